calc3_top: RTL

CALC3_TOP -- requirements
Module: calc3_top

---
 rtl/calc3_top.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/calc3_top.sv
// calc3_top: multi-port two-beat calculator.
// Each port collects a command plus two operands through a small FSM and queues
// the request in a per-port FIFO. One shared ALU serves the FIFO heads
// round-robin and returns a registered one-cycle response on the requesting port.
module calc3_top #(
    parameter int NPORTS = 4,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 2,
    parameter int DEPTH  = 4
) (
    input  logic                     c_clk,
    input  logic                     reset,
    input  logic [4*NPORTS-1:0]      req_cmd_in,
    input  logic [DATA_W*NPORTS-1:0] req_data_in,
    input  logic [TAG_W*NPORTS-1:0]  req_tag_in,
    output logic [NPORTS-1:0]        req_ready,
    output logic [2*NPORTS-1:0]      out_resp,
    output logic [DATA_W*NPORTS-1:0] out_data,
    output logic [TAG_W*NPORTS-1:0]  out_tag
);

    localparam int SH_W  = $clog2(DATA_W);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int RR_W  = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    localparam logic [3:0] CMD_NOP = 4'd0;
    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_SHL = 4'd5;
    localparam logic [3:0] CMD_SHR = 4'd6;

    localparam logic [1:0] RESP_OK  = 2'b01;
    localparam logic [1:0] RESP_ERR = 2'b10;

    // Occupancy limit: a port in OP2 already owns one FIFO slot.
    localparam logic [CNT_W:0] OCC_LIMIT = (CNT_W + 1)'(DEPTH);

    typedef enum logic {
        ST_IDLE,
        ST_OP2
    } port_state_t;

    // Advance a FIFO pointer with wrap at DEPTH (DEPTH need not be a power of two).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // FIFO heads and status, one entry per port.
    logic [NPORTS-1:0]             fifo_empty;
    logic [NPORTS-1:0]             pop_vec;
    logic [NPORTS-1:0][3:0]        head_cmd;
    logic [NPORTS-1:0][TAG_W-1:0]  head_tag;
    logic [NPORTS-1:0][DATA_W-1:0] head_op1;
    logic [NPORTS-1:0][DATA_W-1:0] head_op2;

    // Arbiter and ALU.
    logic [RR_W-1:0]   rr_ptr_reg;
    logic [RR_W-1:0]   rr_ptr_next;
    logic              grant_valid;
    logic [RR_W-1:0]   grant_idx;
    logic [1:0]        alu_resp;
    logic [DATA_W-1:0] alu_data;
    logic [DATA_W:0]   sum_ext;

    // Registered responses.
    logic [NPORTS-1:0][1:0]        out_resp_reg;
    logic [NPORTS-1:0][DATA_W-1:0] out_data_reg;
    logic [NPORTS-1:0][TAG_W-1:0]  out_tag_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NPORTS; gi++) begin : g_port
            port_state_t       state_reg;
            port_state_t       state_next;
            logic [3:0]        cmd_reg;
            logic [TAG_W-1:0]  tag_reg;
            logic [DATA_W-1:0] op1_reg;
            logic              accept;
            logic              push;
            logic [3:0]        cmd_in;
            logic [TAG_W-1:0]  tag_in;
            logic [DATA_W-1:0] data_in;
            logic [CNT_W:0]    occ;

            // FIFO storage is tiny and its head must be visible to the
            // arbiter in the same cycle, so it is read asynchronously.
            logic [3:0]        mem_cmd [DEPTH];
            logic [TAG_W-1:0]  mem_tag [DEPTH];
            logic [DATA_W-1:0] mem_op1 [DEPTH];
            logic [DATA_W-1:0] mem_op2 [DEPTH];
            logic [PTR_W-1:0]  wr_ptr_reg;
            logic [PTR_W-1:0]  rd_ptr_reg;
            logic [CNT_W-1:0]  count_reg;

            assign cmd_in  = req_cmd_in[4*gi +: 4];
            assign tag_in  = req_tag_in[TAG_W*gi +: TAG_W];
            assign data_in = req_data_in[DATA_W*gi +: DATA_W];

            assign occ          = {1'b0, count_reg} + {{CNT_W{1'b0}}, (state_reg == ST_OP2)};
            assign req_ready[gi] = (occ < OCC_LIMIT);

            assign fifo_empty[gi] = (count_reg == '0);
            assign head_cmd[gi]   = mem_cmd[rd_ptr_reg];
            assign head_tag[gi]   = mem_tag[rd_ptr_reg];
            assign head_op1[gi]   = mem_op1[rd_ptr_reg];
            assign head_op2[gi]   = mem_op2[rd_ptr_reg];

            // Port FSM next state: capture on an accepted command, push on operand 2.
            always_comb begin
                state_next = state_reg;
                accept     = 1'b0;
                push       = 1'b0;
                case (state_reg)
                    ST_IDLE: begin
                        if (cmd_in != CMD_NOP && req_ready[gi]) begin
                            accept     = 1'b1;
                            state_next = ST_OP2;
                        end
                    end
                    ST_OP2: begin
                        push       = 1'b1;
                        state_next = ST_IDLE;
                    end
                    default: state_next = ST_IDLE;
                endcase
            end

            // Port FSM state register.
            always_ff @(posedge c_clk) begin
                if (reset) begin
                    state_reg <= ST_IDLE;
                end else begin
                    state_reg <= state_next;
                end
            end

            // Hold command, tag and first operand while waiting for operand 2.
            always_ff @(posedge c_clk) begin
                if (reset) begin
                    cmd_reg <= '0;
                    tag_reg <= '0;
                    op1_reg <= '0;
                end else if (accept) begin
                    cmd_reg <= cmd_in;
                    tag_reg <= tag_in;
                    op1_reg <= data_in;
                end
            end

            // FIFO storage write; contents need no reset since count gates them.
            always_ff @(posedge c_clk) begin
                if (push) begin
                    mem_cmd[wr_ptr_reg] <= cmd_reg;
                    mem_tag[wr_ptr_reg] <= tag_reg;
                    mem_op1[wr_ptr_reg] <= op1_reg;
                    mem_op2[wr_ptr_reg] <= data_in;
                end
            end

            // FIFO pointers and count; simultaneous push and pop leave count unchanged.
            always_ff @(posedge c_clk) begin
                if (reset) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                end else begin
                    if (push) begin
                        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
                    end
                    if (pop_vec[gi]) begin
                        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
                    end
                    case ({push, pop_vec[gi]})
                        2'b10:   count_reg <= count_reg + CNT_W'(1);
                        2'b01:   count_reg <= count_reg - CNT_W'(1);
                        default: count_reg <= count_reg;
                    endcase
                end
            end
        end
    endgenerate

    // Round-robin pick: lowest non-empty port at or above rr_ptr, wrapping.
    always_comb begin
        int cand;
        grant_valid = 1'b0;
        grant_idx   = '0;
        pop_vec     = '0;
        rr_ptr_next = rr_ptr_reg;
        for (int i = 0; i < NPORTS; i++) begin
            cand = int'(rr_ptr_reg) + i;
            if (cand >= NPORTS) begin
                cand = cand - NPORTS;
            end
            if (!grant_valid && !fifo_empty[RR_W'(cand)]) begin
                grant_valid = 1'b1;
                grant_idx   = RR_W'(cand);
            end
        end
        if (grant_valid) begin
            pop_vec[grant_idx] = 1'b1;
            rr_ptr_next = (int'(grant_idx) == NPORTS - 1) ? '0 : grant_idx + RR_W'(1);
        end
    end

    // Shared ALU on the granted FIFO head; arithmetic overflow/underflow report an error.
    always_comb begin
        logic [3:0]        a_cmd;
        logic [DATA_W-1:0] a_op1;
        logic [DATA_W-1:0] a_op2;
        a_cmd    = head_cmd[grant_idx];
        a_op1    = head_op1[grant_idx];
        a_op2    = head_op2[grant_idx];
        alu_resp = RESP_ERR;
        alu_data = '0;
        sum_ext  = {1'b0, a_op1} + {1'b0, a_op2};
        case (a_cmd)
            CMD_ADD: begin
                if (!sum_ext[DATA_W]) begin
                    alu_resp = RESP_OK;
                    alu_data = sum_ext[DATA_W-1:0];
                end
            end
            CMD_SUB: begin
                if (a_op2 <= a_op1) begin
                    alu_resp = RESP_OK;
                    alu_data = a_op1 - a_op2;
                end
            end
            CMD_SHL: begin
                alu_resp = RESP_OK;
                alu_data = a_op1 << a_op2[SH_W-1:0];
            end
            CMD_SHR: begin
                alu_resp = RESP_OK;
                alu_data = a_op1 >> a_op2[SH_W-1:0];
            end
            default: begin
                alu_resp = RESP_ERR;
                alu_data = '0;
            end
        endcase
    end

    // Response registers: cleared every cycle, loaded only on the granted port.
    always_ff @(posedge c_clk) begin
        if (reset) begin
            out_resp_reg <= '0;
            out_data_reg <= '0;
            out_tag_reg  <= '0;
            rr_ptr_reg   <= '0;
        end else begin
            out_resp_reg <= '0;
            out_data_reg <= '0;
            out_tag_reg  <= '0;
            if (grant_valid) begin
                out_resp_reg[grant_idx] <= alu_resp;
                out_data_reg[grant_idx] <= alu_data;
                out_tag_reg[grant_idx]  <= head_tag[grant_idx];
            end
            rr_ptr_reg <= rr_ptr_next;
        end
    end

    assign out_resp = out_resp_reg;
    assign out_data = out_data_reg;
    assign out_tag  = out_tag_reg;

endmodule
